// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: shifts a captured PAT_W-bit pattern out MSB first,
// repeated R times with G idle zero bits between repetitions.
module seq_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [CNT_W-1:0] gap_n,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic [1:0]       ps
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q;      // index of the bit currently on out
  logic [CNT_W-1:0] rep_q;      // repetitions still to send after the current one
  logic [CNT_W-1:0] gap_len_q;
  logic [CNT_W-1:0] gap_cnt_q;

  assign ps = state_q;

  // NOTE: every register here is written with <= so all updates in a cycle see
  // the pre-edge values; mixing in = would make the result depend on statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      out       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            pat_q     <= pattern;
            rep_q     <= (repeat_n == '0) ? '0 : repeat_n - 1'b1;
            gap_len_q <= gap_n;
            idx_q     <= IDX_MSB;
            out       <= pattern[PAT_W-1];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state_q   <= SHIFT;
          end
        end
        SHIFT: begin
          if (idx_q != '0) begin
            idx_q <= idx_q - 1'b1;
            out   <= pat_q[idx_q - 1'b1];
          end else if (rep_q != '0) begin
            rep_q <= rep_q - 1'b1;
            if (gap_len_q != '0) begin
              gap_cnt_q <= gap_len_q;
              out       <= 1'b0;
              out_valid <= 1'b0;
              state_q   <= GAP;
            end else begin
              idx_q <= IDX_MSB;
              out   <= pat_q[PAT_W-1];
            end
          end else begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= DONE;
          end
        end
        GAP: begin
          // gap_cnt_q holds the gap cycles left including the current one
          if (gap_cnt_q == CNT_W'(1)) begin
            idx_q     <= IDX_MSB;
            out       <= pat_q[PAT_W-1];
            out_valid <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: expected per-cycle output records are
// queued when a frame is requested and compared one per clock.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_n;
  logic [CNT_W-1:0] gap_n;
  logic             out;
  logic             out_valid;
  logic             busy;
  logic             done;
  logic [1:0]       ps;

  int total = 0;
  int bad   = 0;

  // record layout: {out, out_valid, busy, done, ps[1:0]}
  logic [5:0] exp_q[$];

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pattern  (pattern),
    .repeat_n (repeat_n),
    .gap_n    (gap_n),
    .out      (out),
    .out_valid(out_valid),
    .busy     (busy),
    .done     (done),
    .ps       (ps)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] observed();
    return {out, out_valid, busy, done, ps};
  endfunction

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(6'b000000);
  endtask

  task automatic push_frame(input logic [PAT_W-1:0] pat, input int r, input int g);
    for (int rr = 0; rr < r; rr++) begin
      for (int b = PAT_W - 1; b >= 0; b--) exp_q.push_back({pat[b], 1'b1, 1'b1, 1'b0, 2'd1});
      if (rr < r - 1)
        for (int gg = 0; gg < g; gg++) exp_q.push_back({1'b0, 1'b0, 1'b1, 1'b0, 2'd2});
    end
    exp_q.push_back({1'b0, 1'b0, 1'b0, 1'b1, 2'd3});
  endtask

  task automatic drive_start(input logic [PAT_W-1:0] pat, input int r, input int g);
    @(negedge clk);
    pattern  = pat;
    repeat_n = CNT_W'(r);
    gap_n    = CNT_W'(g);
    start    = 1'b1;
  endtask

  // Pops one record per clock; mode selects mid-frame input disturbances.
  task automatic check_stream(input string name, input int mode, output int det);
    logic [5:0] exp;
    logic [5:0] got;
    logic [3:0] hist;
    int k;
    hist = '0;
    det  = 0;
    k    = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      got = observed();
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL %s cycle %0d: got {out,vld,busy,done,ps}=%b expected %b", name, k, got, exp);
      end
      if (out_valid === 1'b1) begin
        hist = {hist[2:0], out};
        if (hist == 4'b1010) det++;
      end
      case (mode)
        0: if (k == 0) start = 1'b0;
        1: begin
          if (k == 0) start = 1'b0;
          if (k == 1) begin
            start    = 1'b1;
            pattern  = ~pattern;
            repeat_n = '1;
            gap_n    = '1;
          end
          if (k == 2) start = 1'b0;
        end
        2: begin
          if (k == 1)  pattern = 4'b0110;
          if (k == 7)  pattern = 4'b1001;
          if (k == 13) start = 1'b0;
        end
        default: ;
      endcase
      k++;
    end
  endtask

  task automatic test_reset();
    logic [5:0] got;
    rst      = 1'b1;
    start    = 1'b0;
    pattern  = '0;
    repeat_n = '0;
    gap_n    = '0;
    #3;
    got = observed();
    total++;
    if (got !== 6'b000000) begin
      bad++;
      $display("FAIL reset_async: got %b expected %b", got, 6'b000000);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_idle(2);
    begin
      int det;
      check_stream("reset_idle", 0, det);
    end
  endtask

  task automatic test_single();
    int det;
    drive_start(4'b1010, 1, 0);
    push_frame(4'b1010, 1, 0);
    push_idle(1);
    check_stream("single_1010", 0, det);
  endtask

  task automatic test_continuous();
    int det;
    drive_start(4'b1010, 3, 0);
    push_frame(4'b1010, 3, 0);
    push_idle(1);
    check_stream("continuous_r3", 0, det);
    total++;
    if (det !== 5) begin
      bad++;
      $display("FAIL continuous_detect_count: got %0d expected 5", det);
    end
  endtask

  task automatic test_gap();
    int det;
    drive_start(4'b1101, 2, 2);
    push_frame(4'b1101, 2, 2);
    push_idle(1);
    check_stream("gap_r2_g2", 0, det);
    drive_start(4'b0011, 2, 15);
    push_frame(4'b0011, 2, 15);
    push_idle(1);
    check_stream("gap_max", 0, det);
  endtask

  task automatic test_zero_repeat_ignore_start();
    int det;
    drive_start(4'b1001, 0, 3);
    push_frame(4'b1001, 1, 3);
    push_idle(3);
    check_stream("r0_start_ignored", 1, det);
  endtask

  task automatic test_reset_mid_frame();
    logic [5:0] got;
    int det;
    drive_start(4'b1100, 1, 0);
    push_frame(4'b1100, 1, 0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start = 1'b0;
      total++;
      got = observed();
      if (got !== exp_q[0]) begin
        bad++;
        $display("FAIL reset_mid_pre cycle %0d: got %b expected %b", i, got, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
    #2 rst = 1'b1;
    #1;
    got = observed();
    total++;
    if (got !== 6'b000000) begin
      bad++;
      $display("FAIL reset_mid_async: got %b expected %b", got, 6'b000000);
    end
    exp_q.delete();
    @(negedge clk);
    got = observed();
    total++;
    if (got !== 6'b000000) begin
      bad++;
      $display("FAIL reset_mid_no_done: got %b expected %b", got, 6'b000000);
    end
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b1;
    pattern  = 4'b1100;
    repeat_n = 4'd1;
    gap_n    = 4'd0;
    push_frame(4'b1100, 1, 0);
    push_idle(1);
    check_stream("after_reset_full", 0, det);
  endtask

  task automatic test_back_to_back();
    int det;
    drive_start(4'b1011, 1, 0);
    push_frame(4'b1011, 1, 0);
    push_idle(1);
    push_frame(4'b0110, 1, 0);
    push_idle(1);
    push_frame(4'b1001, 1, 0);
    push_idle(2);
    check_stream("back_to_back", 2, det);
  endtask

  initial begin
    test_reset();
    test_single();
    test_continuous();
    test_gap();
    test_zero_repeat_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
